adder_share_arb: RTL and testbench
==================================

Name: adder_share_arb

Overview:
- Shares one 32-bit carry-lookahead adder (existing cla32) between NREQ requesters, e.g. PC incrementer, branch-target unit and ALU.
- Round-robin grant with a valid/ready request handshake.
- The adder result is registered into a single-entry output stage with a valid/ready response handshake.
- Sits in the KGPminiRISC execute stage; replaces per-unit adders to save area.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, response ID width; must equal clog2(NREQ).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept; one-hot or zero.
- req_a  input  NREQ*32  operand A; requester i uses bits [32i+31:32i].
- req_b  input  NREQ*32  operand B, same packing as req_a.
- req_cin  input  NREQ  carry-in per requester.
- resp_valid  output  1  result register holds a valid result.
- resp_ready  input  1  consumer accepts the result.
- resp_id  output  IDW  index of the requester whose result is held.
- resp_sum  output  32  registered sum.
- resp_cout  output  1  registered carry-out.

Behaviour:
- Reset (rst_n=0, asynchronous): resp_valid=0, resp_id=0, resp_sum=0, resp_cout=0, rr_ptr=0. req_ready is 0 while in reset.
- can_accept = !resp_valid | resp_ready.
- Grant selection (combinational): first i with req_valid[i]=1, searching from rr_ptr upward with wrap-around modulo NREQ.
- req_ready[grant] = can_accept. All other req_ready bits are 0. req_ready is 0 when no request is valid.
- Accept = req_valid[i] & req_ready[i]. On accept:
  - the granted operands pass through the adder combinationally;
  - next edge: resp_sum/resp_cout load the adder result, resp_id = i, resp_valid = 1;
  - rr_ptr = (i+1) mod NREQ.
- Latency: result visible one cycle after accept.
- Throughput: one add per cycle while resp_ready is held high.
- Output drain without accept: resp_valid & resp_ready & no accept -> resp_valid clears next edge. Data registers hold their last value.
- Simultaneous drain and accept: the register reloads and resp_valid stays 1 (no bubble).
- Backpressure: resp_valid=1 & resp_ready=0 -> all req_ready=0. Result register and rr_ptr are frozen.
- rr_ptr does not move when there is no accept.
- Requester rules:
  - must hold req_valid and operands stable until accepted;
  - may not withdraw a request while it is not accepted.
- Arithmetic: sum = (a + b + cin) mod 2^32; cout = bit 32 of the full sum.
- Fairness: any continuously asserting requester is granted within NREQ accepts.
- Reset mid-operation: a pending result is discarded and rr_ptr returns to 0. Requesters must re-present.

Optional Feature:
- Macro ADDER_SHARE_OVF_EN.
- Defined:
  - adds output port resp_ovf (1 bit), registered with resp_sum;
  - resp_ovf = signed overflow = (a[31]==b[31]) & (sum[31]!=a[31]);
  - reset value 0.
- Undefined: the port and its flop are absent.

Decomposition:
- Package adder_share_pkg holds:
  - DATA_W=32;
  - default NREQ and IDW;
  - function rr_pick(valid, ptr), returning the grant index and a found flag.
- One sub-module, rr_arbiter: a parameterised round-robin grant with pointer update on accept.
- The datapath mux, cla32 instance and output register stay in adder_share_arb.

Test Plan:
- Single requester: req_valid=0b0001, a=0xFFFFFFFF, b=0x00000001, cin=0, resp_ready=1.
  -> req_ready=0b0001 same cycle.
  -> Next cycle: resp_valid=1, resp_id=0, resp_sum=0x00000000, resp_cout=1.
- All four requesting continuously, resp_ready=1, from reset.
  -> Grants in order 0,1,2,3,0,1; resp_id follows one cycle later; one result per cycle.
- Backpressure: hold resp_ready=0 with result id=2 pending and req_valid=0b1111.
  -> req_ready=0 and outputs stable for 5 cycles.
  -> On resp_ready=1, the same cycle grants id 3; its result appears next cycle with no bubble.
- Wrap-around: rr_ptr=3, req_valid=0b0101.
  -> Grant 0, then 2, then 0 again.
- Async reset: assert rst_n=0 mid-stream, between clock edges, with resp_valid=1.
  -> resp_valid=0 immediately.
  -> After release, the first grant goes to the lowest valid index.
- With ADDER_SHARE_OVF_EN: a=0x7FFFFFFF, b=0x00000001, cin=0.
  -> resp_sum=0x80000000, resp_ovf=1, resp_cout=0.

Source files
------------

// File: rtl/adder_share_pkg.sv
// Shared types, widths and the round-robin pick helper for adder_share_arb.
package adder_share_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NREQ_DEF = 4;
  localparam int unsigned IDW_DEF  = 2;
  localparam int unsigned PICK_W   = 3;
  localparam int unsigned MAX_REQ  = 8;

  typedef struct packed {
    logic              found;
    logic [PICK_W-1:0] idx;
  } rr_pick_t;

  // First valid index at or above ptr, wrapping modulo n (n <= MAX_REQ).
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                       input logic [PICK_W-1:0] ptr,
                                       input int unsigned n);
    rr_pick_t    r;
    int unsigned j;
    r = '0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      j = (32'(ptr) + k) % n;
      if (k < n && !r.found && valid[j[PICK_W-1:0]]) begin
        r.found = 1'b1;
        r.idx   = PICK_W'(j);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/cla32.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups with rippled group carry.
module cla32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [31:0] g;
  logic [31:0] p;
  logic [32:0] c;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    c    = '0;
    c[0] = cin;
    for (int grp = 0; grp < 8; grp++) begin
      c[4*grp+1] = g[4*grp] | (p[4*grp] & c[4*grp]);
      c[4*grp+2] = g[4*grp+1] | (p[4*grp+1] & g[4*grp])
                 | (p[4*grp+1] & p[4*grp] & c[4*grp]);
      c[4*grp+3] = g[4*grp+2] | (p[4*grp+2] & g[4*grp+1])
                 | (p[4*grp+2] & p[4*grp+1] & g[4*grp])
                 | (p[4*grp+2] & p[4*grp+1] & p[4*grp] & c[4*grp]);
      c[4*grp+4] = g[4*grp+3] | (p[4*grp+3] & g[4*grp+2])
                 | (p[4*grp+3] & p[4*grp+2] & g[4*grp+1])
                 | (p[4*grp+3] & p[4*grp+2] & p[4*grp+1] & g[4*grp])
                 | (p[4*grp+3] & p[4*grp+2] & p[4*grp+1] & p[4*grp] & c[4*grp]);
    end
  end

  assign sum  = p ^ c[31:0];
  assign cout = c[32];

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin grant over NREQ requesters; pointer advances past the winner on accept.
module rr_arbiter
  import adder_share_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned IDW  = IDW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] reqValid,
  input  logic            canAccept,
  output logic [NREQ-1:0] grantOh_c,
  output logic [IDW-1:0]  grantIdx_c,
  output logic            accept_c
);

  rr_pick_t       pick;
  logic [IDW-1:0] rrPtr;

  always_comb begin
    pick       = rr_pick(MAX_REQ'(reqValid), PICK_W'(rrPtr), NREQ);
    grantIdx_c = IDW'(pick.idx);
    accept_c   = pick.found & canAccept;
    grantOh_c  = accept_c ? (NREQ'(1) << grantIdx_c) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rrPtr <= '0;
    end else if (accept_c) begin
      rrPtr <= (grantIdx_c == IDW'(NREQ - 1)) ? '0 : grantIdx_c + 1'b1;
    end
  end

endmodule

// File: rtl/adder_share_arb.sv
// One cla32 shared round-robin among NREQ requesters with a registered result stage.
// Define ADDER_SHARE_OVF_EN to add the registered signed-overflow output resp_ovf.
module adder_share_arb
  import adder_share_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned IDW  = IDW_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*DATA_W-1:0] req_a,
  input  logic [NREQ*DATA_W-1:0] req_b,
  input  logic [NREQ-1:0]        req_cin,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [IDW-1:0]         resp_id,
  output logic [DATA_W-1:0]      resp_sum,
  output logic                   resp_cout
`ifdef ADDER_SHARE_OVF_EN
  ,
  output logic                   resp_ovf
`endif
);

  logic              canAccept;
  logic              accept;
  logic [IDW-1:0]    grantIdx;
  logic [DATA_W-1:0] opA;
  logic [DATA_W-1:0] opB;
  logic              opCin;
  logic [DATA_W-1:0] sumC;
  logic              coutC;

  // Nothing is offered while reset is asserted.
  assign canAccept = rst_n & (~resp_valid | resp_ready);

  rr_arbiter #(
    .NREQ(NREQ),
    .IDW (IDW)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .reqValid  (req_valid),
    .canAccept (canAccept),
    .grantOh_c (req_ready),
    .grantIdx_c(grantIdx),
    .accept_c  (accept)
  );

  always_comb begin
    opA   = '0;
    opB   = '0;
    opCin = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (IDW'(i) == grantIdx) begin
        opA   = req_a[i*DATA_W +: DATA_W];
        opB   = req_b[i*DATA_W +: DATA_W];
        opCin = req_cin[i];
      end
    end
  end

  cla32 u_cla (
    .a   (opA),
    .b   (opB),
    .cin (opCin),
    .sum (sumC),
    .cout(coutC)
  );

  // Result stage: reload on accept (even while draining), clear valid on a bare drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_sum   <= '0;
      resp_cout  <= 1'b0;
    end else if (accept) begin
      resp_valid <= 1'b1;
      resp_id    <= grantIdx;
      resp_sum   <= sumC;
      resp_cout  <= coutC;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

`ifdef ADDER_SHARE_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_ovf <= 1'b0;
    end else if (accept) begin
      resp_ovf <= (opA[DATA_W-1] == opB[DATA_W-1]) & (sumC[DATA_W-1] != opA[DATA_W-1]);
    end
  end
`endif

endmodule

// File: tb/tb_adder_share_arb.sv
// Directed bench for adder_share_arb with a scoreboard of expected results.
module tb_adder_share_arb;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [3:0]   req_cin;
  logic         resp_valid;
  logic         resp_ready;
  logic [1:0]   resp_id;
  logic [31:0]  resp_sum;
  logic         resp_cout;
`ifdef ADDER_SHARE_OVF_EN
  logic         resp_ovf;
`endif

  exp_t        sb[$];
  int          mPtr;
  logic        mValid;
  int          checks = 0;
  int          errors = 0;
  logic [3:0]  seenReady;
  logic [31:0] heldSum;

  always #5 clk = ~clk;

  adder_share_arb dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_id   (resp_id),
    .resp_sum  (resp_sum),
    .resp_cout (resp_cout)
`ifdef ADDER_SHARE_OVF_EN
    ,
    .resp_ovf  (resp_ovf)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic int ohIdx(input logic [3:0] oh);
    int r;
    r = -1;
    for (int i = 0; i < 4; i++) if (oh[i]) r = i;
    return r;
  endfunction

  function automatic exp_t model(input int i);
    exp_t        e;
    logic [32:0] s;
    logic [31:0] a;
    logic [31:0] b;
    a      = req_a[i*32 +: 32];
    b      = req_b[i*32 +: 32];
    s      = {1'b0, a} + {1'b0, b} + 33'(req_cin[i]);
    e.id   = 2'(i);
    e.sum  = s[31:0];
    e.cout = s[32];
    e.ovf  = (a[31] == b[31]) && (s[31] != a[31]);
    return e;
  endfunction

  task automatic setOp(input int i, input logic [31:0] a, input logic [31:0] b, input logic c);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
    req_cin[i]        = c;
  endtask

  // One clock: check handshake at the falling edge, score any drained result, advance the model.
  task automatic cycle();
    logic [3:0] expRdy;
    int         g;
    exp_t       e;
    @(negedge clk);
    g = -1;
    for (int k = 0; k < 4; k++) begin
      if (g < 0 && req_valid[(mPtr + k) % 4]) g = (mPtr + k) % 4;
    end
    expRdy = (g >= 0 && (!mValid || resp_ready)) ? 4'(1 << g) : 4'b0000;
    chk("req_ready", 64'(req_ready), 64'(expRdy));
    chk("resp_valid", 64'(resp_valid), 64'(mValid));
    seenReady = req_ready;
    if (resp_valid && resp_ready) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL scoreboard: observed unexpected result id %0d required none", resp_id);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("resp_id", 64'(resp_id), 64'(e.id));
        chk("resp_sum", 64'(resp_sum), 64'(e.sum));
        chk("resp_cout", 64'(resp_cout), 64'(e.cout));
`ifdef ADDER_SHARE_OVF_EN
        chk("resp_ovf", 64'(resp_ovf), 64'(e.ovf));
`endif
      end
    end
    if (expRdy != 4'b0000) begin
      sb.push_back(model(g));
      mPtr   = (g + 1) % 4;
      mValid = 1'b1;
    end else if (resp_ready) begin
      mValid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n      = 1'b0;
    req_valid  = 4'hF;
    resp_ready = 1'b0;
    sb.delete();
    mPtr   = 0;
    mValid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst req_ready", 64'(req_ready), 64'h0);
    chk("rst resp_valid", 64'(resp_valid), 64'h0);
    chk("rst resp_id", 64'(resp_id), 64'h0);
    chk("rst resp_sum", 64'(resp_sum), 64'h0);
    chk("rst resp_cout", 64'(resp_cout), 64'h0);
    req_valid = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    req_a   = '0;
    req_b   = '0;
    req_cin = '0;
    doReset();

    // Single requester, carry out of bit 31.
    setOp(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    req_valid  = 4'b0001;
    resp_ready = 1'b1;
    cycle();
    chk("single grant", 64'(seenReady), 64'h1);
    chk("single sum", 64'(resp_sum), 64'h0);
    chk("single cout", 64'(resp_cout), 64'h1);
    chk("single id", 64'(resp_id), 64'h0);
    req_valid = 4'b0000;
    cycle();

    // All four requesting from reset: strict rotation, one result per cycle.
    doReset();
    for (int i = 0; i < 4; i++) setOp(i, $urandom, $urandom, 1'($urandom));
    req_valid  = 4'b1111;
    resp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("rotation grant", 64'(ohIdx(seenReady)), 64'(k % 4));
    end

    // Backpressure with id 2 pending.
    cycle();
    chk("bp pending id", 64'(resp_id), 64'h2);
    resp_ready = 1'b0;
    heldSum    = resp_sum;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("bp hold id", 64'(resp_id), 64'h2);
      chk("bp hold sum", 64'(resp_sum), 64'(heldSum));
    end
    resp_ready = 1'b1;
    cycle();
    chk("bp release grant", 64'(seenReady), 64'h8);
    chk("bp no bubble valid", 64'(resp_valid), 64'h1);
    chk("bp no bubble id", 64'(resp_id), 64'h3);

    // Bring pointer to 3, then wrap between requesters 0 and 2.
    setOp(2, 32'h1234_5678, 32'h8765_4321, 1'b1);
    req_valid = 4'b0100;
    cycle();
    chk("to ptr3 grant", 64'(seenReady), 64'h4);
    req_valid = 4'b0101;
    cycle();
    chk("wrap grant 0", 64'(ohIdx(seenReady)), 64'h0);
    cycle();
    chk("wrap grant 2", 64'(ohIdx(seenReady)), 64'h2);
    cycle();
    chk("wrap grant 0 again", 64'(ohIdx(seenReady)), 64'h0);

    // Asynchronous reset between edges with a result held.
    chk("pre-reset valid", 64'(resp_valid), 64'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("async reset valid", 64'(resp_valid), 64'h0);
    chk("async reset ready", 64'(req_ready), 64'h0);
    sb.delete();
    mPtr      = 0;
    mValid    = 1'b0;
    req_valid = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 4'b0110;
    cycle();
    chk("post-reset grant", 64'(seenReady), 64'h2);

    // Signed overflow and all-ones with carry-in.
    setOp(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    req_valid = 4'b0001;
    cycle();
    chk("ovf sum", 64'(resp_sum), 64'h8000_0000);
    chk("ovf cout", 64'(resp_cout), 64'h0);
`ifdef ADDER_SHARE_OVF_EN
    chk("ovf flag", 64'(resp_ovf), 64'h1);
`endif
    setOp(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    req_valid = 4'b1000;
    cycle();
    chk("ones sum", 64'(resp_sum), 64'hFFFF_FFFF);
    chk("ones cout", 64'(resp_cout), 64'h1);

    // Drain and confirm nothing is left outstanding.
    req_valid = 4'b0000;
    cycle();
    cycle();
    chk("scoreboard empty", 64'(sb.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
